// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master: FSM state encoding, default field
// lengths and SCL half-period, plus a helper that classifies bit-clocking states.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    StIdle          = 4'd0,
    StReady         = 4'd1,
    StSendAddress   = 4'd2,
    StCheckAck      = 4'd3,
    StWriteData     = 4'd4,
    StOutputData    = 4'd5,
    StReadData      = 4'd6,
    StStoreData     = 4'd7,
    StCheckForValid = 4'd8,
    StSendAck       = 4'd9,
    StSendNack      = 4'd10,
    StStop          = 4'd11
  } state_e;

  localparam int unsigned ThresholdDef = 2;
  localparam int unsigned AddrLenDef   = 7;
  localparam int unsigned DataLenDef   = 8;
  localparam int unsigned CountW       = 7;
  // Wide enough for 2*THRESHOLD-1 with THRESHOLD up to 7.
  localparam int unsigned PhW          = 4;

  // States in which SCL toggles once per bit.
  function automatic logic is_bit_state(input logic [3:0] s);
    return s inside {StSendAddress, StReadData, StWriteData, StOutputData, StCheckAck,
                     StStoreData, StCheckForValid, StSendAck, StSendNack};
  endfunction

endpackage

// File: rtl/scl_phase_div.sv
// SCL phase divider: owns the bit-phase counter and the registered SCL level.
// SCL is derived from the next-state phase so it is aligned with the phase
// counter (low half first).
module scl_phase_div
  import i2c_master_pkg::*;
#(
  parameter int unsigned THRESHOLD = ThresholdDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_state,
  input  logic       i_wait_for_sync,
  input  logic       i_freeze,
  input  logic       i_stop_high,
  output logic       o_scl
);

  localparam logic [PhW-1:0] PhMax  = PhW'(2 * THRESHOLD - 1);
  localparam logic [PhW-1:0] PhHigh = PhW'(THRESHOLD);

  logic [PhW-1:0] r_ph;
  logic [PhW-1:0] w_ph_d;
  logic           r_scl;
  logic           w_scl_d;

  // Phase next-state: sync pulse clears, bit states wrap modulo 2*THRESHOLD.
  always_comb begin
    w_ph_d = r_ph;
    if (i_wait_for_sync) begin
      w_ph_d = '0;
    end else if (!i_freeze && is_bit_state(i_state)) begin
      w_ph_d = (r_ph == PhMax) ? '0 : r_ph + 1'b1;
    end
  end

  // SCL next-state; undefined encodings fall through to the Idle level.
  always_comb begin
    w_scl_d = 1'b1;
    if (i_freeze) begin
      w_scl_d = r_scl;
    end else begin
      case (i_state)
        StReady: w_scl_d = r_scl & ~i_wait_for_sync;
        StStop:  w_scl_d = i_stop_high;
        default: w_scl_d = is_bit_state(i_state) ? (w_ph_d >= PhHigh) : 1'b1;
      endcase
    end
  end

  // Phase and SCL registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph  <= '0;
      r_scl <= 1'b1;
    end else begin
      r_ph  <= w_ph_d;
      r_scl <= w_scl_d;
    end
  end

  assign o_scl = r_scl;

endmodule

// File: rtl/scl_timing_gen.sv
// SCL timing generator for the I2C master: free-running saturating cycle
// counter, SCL generation and field-complete decodes.
// Optional build macro SCL_STRETCH_EN adds scl_in and freezes counting while a
// slave holds SCL low against a released (high) SCL.
module scl_timing_gen
  import i2c_master_pkg::*;
#(
  parameter int unsigned THRESHOLD = ThresholdDef,
  parameter int unsigned ADDR_LEN  = AddrLenDef,
  parameter int unsigned DATA_LEN  = DataLenDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        state_master,
  input  logic              rst_count,
`ifdef SCL_STRETCH_EN
  input  logic              scl_in,
`endif
  output logic              scl,
  output logic [CountW-1:0] count_ctrl,
  output logic              wait_for_sync,
  output logic              add_sent,
  output logic              data_received,
  output logic              data_sent
);

  localparam logic [CountW-1:0] CountMax = '1;
  localparam logic [CountW-1:0] SyncCnt  = CountW'(3 * THRESHOLD);
  localparam logic [CountW-1:0] StopCnt  = CountW'(2 * THRESHOLD);
  localparam logic [CountW-1:0] AddrCnt  = CountW'(2 * THRESHOLD * ADDR_LEN);
  localparam logic [CountW-1:0] DataCnt  = CountW'(2 * THRESHOLD * DATA_LEN);

  logic [CountW-1:0] r_count;
  logic [CountW-1:0] w_count_d;
  logic              w_freeze;

`ifdef SCL_STRETCH_EN
  // Slave is stretching: we released SCL but the bus still reads low.
  assign w_freeze = scl & ~scl_in;
`else
  assign w_freeze = 1'b0;
`endif

  // Counter next-state: clear wins over freeze and saturation.
  always_comb begin
    w_count_d = r_count;
    if (rst_count) begin
      w_count_d = '0;
    end else if (!w_freeze) begin
      w_count_d = (r_count == CountMax) ? r_count : r_count + 1'b1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign count_ctrl    = r_count;
  assign wait_for_sync = (state_master == StReady) && (r_count == SyncCnt);
  assign add_sent      = (state_master == StSendAddress) && (r_count >= AddrCnt);
  assign data_received = (state_master == StStoreData) && (r_count >= DataCnt);
  assign data_sent     = (state_master == StOutputData) && (r_count >= DataCnt);

  scl_phase_div #(
    .THRESHOLD (THRESHOLD)
  ) u_phase_div (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_state         (state_master),
    .i_wait_for_sync (wait_for_sync),
    .i_freeze        (w_freeze),
    .i_stop_high     (w_count_d >= StopCnt),
    .o_scl           (scl)
  );

endmodule
